alu_serial: RTL and testbench
=============================

ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width, equal to log2(XLEN).
REQ-003 SHALL have port i_clk, input, 1, the sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_ALUControlLines, input, 4, operation code from the shared ALU control encoding.
REQ-006 SHALL have port i_A, input, XLEN, operand 1.
REQ-007 SHALL have port i_B, input, XLEN, operand 2; bits [SHAMT_W-1:0] are the shift amount.
REQ-008 SHALL have port i_valid, input, 1, request valid.
REQ-009 SHALL have port o_ready, output, 1, request accepted when i_valid && o_ready.
REQ-010 SHALL have port o_Result, output, XLEN, registered result.
REQ-011 SHALL have port o_Zero, output, 1, high when o_Result == 0.
REQ-012 SHALL have port o_valid, output, 1, result valid.
REQ-013 SHALL have port i_ready, input, 1, result consumed when o_valid && i_ready.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 SHALL capture code, i_A and i_B on acceptance; inputs are don't-care otherwise.
REQ-016 SHALL compute ADD, SUB, SLT, SLTU, XOR, OR, AND and S1 (result = i_A) in one cycle: acceptance -> DONE with o_valid high on the next cycle.
REQ-017 SHALL compute SLT signed and SLTU unsigned, result zero-extended 0/1; ADD/SUB SHALL wrap modulo 2^XLEN.
REQ-018 SHALL execute SLL, SRL and SRA one bit position per cycle in SHIFT, decrementing a SHAMT_W-bit counter.
REQ-019 SHALL fill SRA with the captured sign bit on every step.
REQ-020 SHALL make shift latency shamt+1 cycles from acceptance to o_valid; shamt 0 SHALL skip SHIFT (latency 1), and shamt XLEN-1 SHALL take XLEN cycles.
REQ-021 SHALL treat undefined codes as one-cycle ops with result 0.
REQ-022 SHALL hold o_Result, o_Zero and o_valid stable in DONE until i_ready is high.
REQ-023 SHALL drive o_ready = (state==IDLE) || (state==DONE && i_ready), allowing back-to-back ops with no bubble.
REQ-024 SHALL, on a simultaneous consume and accept in DONE, load the new op, and o_valid SHALL stay high only if the next op completes in that following cycle.
REQ-025 SHALL, in DONE with i_ready low, keep o_ready low and drop new requests (the producer holds i_valid).
REQ-026 SHALL keep o_ready low throughout SHIFT; ops are non-preemptible.
REQ-027 SHALL derive o_Zero from the registered result with no extra latency.

Reset
REQ-028 SHALL on i_rst asynchronously enter IDLE, with o_valid=0, o_Result=0, o_Zero=1, shift counter=0.
REQ-029 SHALL make o_ready 1 in the first cycle after reset release.
REQ-030 SHALL abort any op in flight on mid-SHIFT or mid-DONE reset, producing no o_valid pulse for it.

Structure
REQ-031 SHALL place the 4-bit ALU control codes and the FSM state enum in the shared ALU package/defines; no local redefinition.
REQ-032 SHALL instantiate one combinational sub-module, alu_single, computing all one-cycle ops and the zero flag.
REQ-033 SHALL keep the shift datapath (register, counter, fill bit) in alu_serial.

Verification
REQ-034 SHALL cover: ADD A=0xFFFFFFFF, B=1 -> one cycle later o_valid=1, o_Result=0, o_Zero=1.
REQ-035 SHALL cover: SRA A=0x80000000, B=31 -> o_valid 32 cycles after acceptance, o_Result=0xFFFFFFFF, o_ready low meanwhile.
REQ-036 SHALL cover: SLL A=1, B=0 -> latency 1, o_Result=1; SLT A=-1, B=1 -> 1; SLTU same operands -> 0.
REQ-037 SHALL cover: back-to-back ADD, XOR with i_ready=1 -> two consecutive o_valid cycles, no bubble.
REQ-038 SHALL cover: i_ready held low 5 cycles in DONE -> o_Result stable, o_ready=0, a second request is not taken until i_ready rises.
REQ-039 SHALL cover: i_rst asserted in cycle 3 of SRL A=0xF0, B=8 -> immediate IDLE, o_valid never asserted, o_ready=1 after release.

Source files
------------

// File: rtl/alu_serial_pkg.sv
// Shared ALU definitions: 4-bit ALU control encoding, serial-ALU FSM states,
// and a helper that classifies the multi-cycle shift operations.
package alu_serial_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'h0,
    ALU_OR   = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_XOR  = 4'h3,
    ALU_SLL  = 4'h4,
    ALU_SRL  = 4'h5,
    ALU_SUB  = 4'h6,
    ALU_SLT  = 4'h7,
    ALU_SLTU = 4'h8,
    ALU_SRA  = 4'h9,
    ALU_S1   = 4'hA
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_serial_single.sv
// alu_single: combinational ALU for every one-cycle operation, plus the zero
// detector used on the registered result of the serial ALU.
// Ports:
//   code     - ALU control code
//   a, b     - operands
//   result   - one-cycle result (0 for shift and undefined codes)
//   zero_src - value to test for zero (the registered result)
//   zero     - high when zero_src == 0
module alu_single
  import alu_serial_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      code,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] zero_src,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (code)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result[0] = ($signed(a) < $signed(b));
      ALU_SLTU: result[0] = (a < b);
      ALU_XOR:  result = a ^ b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_S1:   result = a;
      default:  result = '0;
    endcase
  end

  assign zero = (zero_src == '0);

endmodule

// File: rtl/alu_serial.sv
// alu_serial: valid/ready ALU. One-cycle ops complete on the cycle after
// acceptance; SLL/SRL/SRA shift one bit per cycle (latency shamt+1).
// Ports:
//   i_clk, i_rst         - clock, asynchronous active-high reset
//   i_ALUControlLines    - operation code
//   i_A, i_B             - operands (i_B[SHAMT_W-1:0] = shift amount)
//   i_valid / o_ready    - request handshake
//   o_Result, o_Zero     - registered result and its zero flag
//   o_valid / i_ready    - result handshake
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [3:0]      i_ALUControlLines,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  input  logic            i_valid,
  output logic            o_ready,
  output logic [XLEN-1:0] o_Result,
  output logic            o_Zero,
  output logic            o_valid,
  input  logic            i_ready
);

  alu_state_e        state_q, state_d;
  logic [3:0]        op_q;
  logic [XLEN-1:0]   shreg_q, res_q, shift_nxt, alu_res, quick_res;
  logic [SHAMT_W-1:0] cnt_q;
  logic              fill_q;
  logic              accept, in_shift, go_shift;

  alu_single #(.XLEN(XLEN)) u_alu_single (
    .code     (i_ALUControlLines),
    .a        (i_A),
    .b        (i_B),
    .result   (alu_res),
    .zero_src (res_q),
    .zero     (o_Zero)
  );

  assign o_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && i_ready);
  assign accept   = i_valid && o_ready;
  assign o_valid  = (state_q == ST_DONE);
  assign o_Result = res_q;

  assign in_shift  = is_shift_op(i_ALUControlLines);
  assign go_shift  = in_shift && (i_B[SHAMT_W-1:0] != '0);
  // A zero-distance shift is just a pass-through of A.
  assign quick_res = in_shift ? i_A : alu_res;

  always_comb begin
    shift_nxt = shreg_q;
    case (op_q)
      ALU_SLL: shift_nxt = {shreg_q[XLEN-2:0], 1'b0};
      ALU_SRL: shift_nxt = {1'b0, shreg_q[XLEN-1:1]};
      ALU_SRA: shift_nxt = {fill_q, shreg_q[XLEN-1:1]};
      default: shift_nxt = shreg_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = go_shift ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (i_ready) begin
          if (accept) state_d = go_shift ? ST_SHIFT : ST_DONE;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // The last shift step writes the result register directly so DONE is
  // entered with the final value already in place.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q    <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      res_q   <= '0;
    end else if (accept) begin
      op_q    <= i_ALUControlLines;
      shreg_q <= i_A;
      cnt_q   <= i_B[SHAMT_W-1:0];
      fill_q  <= (i_ALUControlLines == ALU_SRA) ? i_A[XLEN-1] : 1'b0;
      if (!go_shift) res_q <= quick_res;
    end else if (state_q == ST_SHIFT) begin
      shreg_q <= shift_nxt;
      cnt_q   <= cnt_q - SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(1)) res_q <= shift_nxt;
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Directed testbench for alu_serial: reset state, one-cycle ops, serial
// shifts with latency, back-to-back handshake, output stall and mid-op reset.
module tb_alu_serial;
  import alu_serial_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  code;
  logic [31:0] a, b;
  logic        vin, rdy_out, vout, rdy_in, zero;
  logic [31:0] res;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_serial #(.XLEN(32), .SHAMT_W(5)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_ALUControlLines(code),
    .i_A              (a),
    .i_B              (b),
    .i_valid          (vin),
    .o_ready          (rdy_out),
    .o_Result         (res),
    .o_Zero           (zero),
    .o_valid          (vout),
    .i_ready          (rdy_in)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    code = c; a = x; b = y; vin = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vin = 1'b0; rdy_in = 1'b1; code = '0; a = '0; b = '0;
    step(); step();
    total++; if (vout !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", vout); end
    total++; if (res !== 32'h0) begin bad++; $display("FAIL rst_result: got %h want 00000000", res); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL rst_zero: got %b want 1", zero); end
    rst = 1'b0;
    step();
    total++; if (rdy_out !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", rdy_out); end
    total++; if (vout !== 1'b0) begin bad++; $display("FAIL rst_release_valid: got %b want 0", vout); end
  endtask

  task automatic test_one_cycle();
    logic [3:0]  t_op  [0:12];
    logic [31:0] t_a   [0:12];
    logic [31:0] t_b   [0:12];
    logic [31:0] t_exp [0:12];
    t_op  = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SLT, ALU_SLTU, ALU_XOR,
              ALU_OR, ALU_AND, ALU_S1, ALU_SLL, 4'hF, ALU_SRA};
    t_a   = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7, 32'h7, 32'hF0F0F0F0,
              32'h12340000, 32'hF0F0F0F0, 32'hDEADBEEF, 32'h1, 32'h5, 32'h80000000};
    t_b   = '{32'h1, 32'h1, 32'h1, 32'h1, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFF00FF00,
              32'h00005678, 32'hFF00FF00, 32'h123, 32'h0, 32'h3, 32'hE0};
    t_exp = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0FF00FF0,
              32'h12345678, 32'hF000F000, 32'hDEADBEEF, 32'h1, 32'h0, 32'h80000000};
    for (int i = 0; i < 13; i++) begin
      rdy_in = 1'b1;
      drive(t_op[i], t_a[i], t_b[i]);
      step();
      vin = 1'b0;
      total++; if (vout !== 1'b1) begin bad++; $display("FAIL op%0d_valid: got %b want 1", i, vout); end
      total++; if (res !== t_exp[i]) begin bad++; $display("FAIL op%0d_result: got %h want %h", i, res, t_exp[i]); end
      total++; if (zero !== (t_exp[i] == 32'h0)) begin bad++; $display("FAIL op%0d_zero: got %b want %b", i, zero, (t_exp[i] == 32'h0)); end
      step();
      total++; if (vout !== 1'b0) begin bad++; $display("FAIL op%0d_idle: got %b want 0", i, vout); end
    end
  endtask

  task automatic test_shift();
    logic [3:0]  t_op  [0:6];
    logic [31:0] t_a   [0:6];
    logic [31:0] t_b   [0:6];
    logic [31:0] t_exp [0:6];
    int          t_lat [0:6];
    int  cyc;
    logic ready_ok;
    t_op  = '{ALU_SRA, ALU_SRL, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLL, ALU_SRA};
    t_a   = '{32'h80000000, 32'h80000000, 32'h1, 32'hF0, 32'h80000000, 32'h0000FFFF, 32'h7FFFFFFF};
    t_b   = '{32'd31, 32'd31, 32'd31, 32'd8, 32'h24, 32'd4, 32'd3};
    t_exp = '{32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h0, 32'hF8000000, 32'h000FFFF0, 32'h0FFFFFFF};
    t_lat = '{32, 32, 32, 9, 5, 5, 4};
    for (int i = 0; i < 7; i++) begin
      rdy_in = 1'b1;
      drive(t_op[i], t_a[i], t_b[i]);
      step();
      vin = 1'b0;
      cyc = 1;
      ready_ok = 1'b1;
      while (vout !== 1'b1 && cyc < 64) begin
        if (rdy_out !== 1'b0) ready_ok = 1'b0;
        step();
        cyc++;
      end
      total++; if (vout !== 1'b1 || cyc != t_lat[i]) begin bad++; $display("FAIL sh%0d_latency: got %0d (valid %b) want %0d", i, cyc, vout, t_lat[i]); end
      total++; if (res !== t_exp[i]) begin bad++; $display("FAIL sh%0d_result: got %h want %h", i, res, t_exp[i]); end
      total++; if (zero !== (t_exp[i] == 32'h0)) begin bad++; $display("FAIL sh%0d_zero: got %b want %b", i, zero, (t_exp[i] == 32'h0)); end
      total++; if (ready_ok !== 1'b1) begin bad++; $display("FAIL sh%0d_ready_low: got %b want 1", i, ready_ok); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    rdy_in = 1'b1;
    drive(ALU_ADD, 32'd3, 32'd4);
    step();
    total++; if (vout !== 1'b1) begin bad++; $display("FAIL b2b_first_valid: got %b want 1", vout); end
    total++; if (res !== 32'd7) begin bad++; $display("FAIL b2b_first_result: got %h want 00000007", res); end
    drive(ALU_XOR, 32'hFF, 32'h0F);
    #1;
    total++; if (rdy_out !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", rdy_out); end
    step();
    vin = 1'b0;
    total++; if (vout !== 1'b1) begin bad++; $display("FAIL b2b_second_valid: got %b want 1", vout); end
    total++; if (res !== 32'hF0) begin bad++; $display("FAIL b2b_second_result: got %h want 000000f0", res); end
    step();
    total++; if (vout !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", vout); end
  endtask

  task automatic test_stall();
    rdy_in = 1'b0;
    drive(ALU_ADD, 32'd10, 32'd20);
    step();
    drive(ALU_SUB, 32'd100, 32'd1);
    for (int k = 0; k < 5; k++) begin
      total++; if (rdy_out !== 1'b0) begin bad++; $display("FAIL stall%0d_ready: got %b want 0", k, rdy_out); end
      total++; if (vout !== 1'b1) begin bad++; $display("FAIL stall%0d_valid: got %b want 1", k, vout); end
      total++; if (res !== 32'd30) begin bad++; $display("FAIL stall%0d_result: got %h want 0000001e", k, res); end
      step();
    end
    rdy_in = 1'b1;
    #1;
    total++; if (rdy_out !== 1'b1) begin bad++; $display("FAIL stall_release_ready: got %b want 1", rdy_out); end
    step();
    vin = 1'b0;
    total++; if (vout !== 1'b1) begin bad++; $display("FAIL stall_second_valid: got %b want 1", vout); end
    total++; if (res !== 32'd99) begin bad++; $display("FAIL stall_second_result: got %h want 00000063", res); end
    step();
    total++; if (vout !== 1'b0) begin bad++; $display("FAIL stall_idle: got %b want 0", vout); end
  endtask

  task automatic test_reset_midop();
    logic seen;
    seen = 1'b0;
    rdy_in = 1'b1;
    drive(ALU_SRL, 32'hF0, 32'd8);
    step();
    vin = 1'b0;
    if (vout === 1'b1) seen = 1'b1;
    step();
    if (vout === 1'b1) seen = 1'b1;
    step();
    if (vout === 1'b1) seen = 1'b1;
    rst = 1'b1;
    #1;
    total++; if (vout !== 1'b0) begin bad++; $display("FAIL midshift_rst_valid: got %b want 0", vout); end
    total++; if (res !== 32'h0) begin bad++; $display("FAIL midshift_rst_result: got %h want 00000000", res); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL midshift_rst_zero: got %b want 1", zero); end
    step(); step();
    rst = 1'b0;
    step();
    total++; if (rdy_out !== 1'b1) begin bad++; $display("FAIL midshift_release_ready: got %b want 1", rdy_out); end
    for (int k = 0; k < 12; k++) begin
      if (vout === 1'b1) seen = 1'b1;
      step();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midshift_no_valid: got %b want 0", seen); end

    rdy_in = 1'b0;
    drive(ALU_ADD, 32'd1, 32'd1);
    step();
    vin = 1'b0;
    total++; if (res !== 32'd2 || vout !== 1'b1) begin bad++; $display("FAIL middone_pre: got %h/%b want 00000002/1", res, vout); end
    rst = 1'b1;
    #1;
    total++; if (vout !== 1'b0) begin bad++; $display("FAIL middone_rst_valid: got %b want 0", vout); end
    total++; if (res !== 32'h0) begin bad++; $display("FAIL middone_rst_result: got %h want 00000000", res); end
    rst = 1'b0;
    step();
    total++; if (rdy_out !== 1'b1 || vout !== 1'b0) begin bad++; $display("FAIL middone_release: got ready %b valid %b want 1/0", rdy_out, vout); end
  endtask

  initial begin
    test_reset();
    test_one_cycle();
    test_shift();
    test_back_to_back();
    test_stall();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
